reset_sequencer: RTL and testbench



---
 rtl/reset_seq_pkg.sv | 24 ++
 rtl/sync_2ff.sv | 23 ++
 rtl/reset_sequencer.sv | 136 +++++++++++++
 tb/tb_reset_sequencer.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/reset_seq_pkg.sv
// Shared state encoding and reset-release decode for the reset sequencer.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package reset_seq_pkg;

    typedef enum logic [2:0] {
        WAIT_LOCK  = 3'd0,
        DDR_HOLD   = 3'd1,
        WAIT_CALIB = 3'd2,
        RUN        = 3'd3,
        SYS_HOLD   = 3'd4
    } state_t;

    // Bits are {dbg, ddr, sys}; a 1 means that domain is out of reset.
    function automatic logic [2:0] rst_release(state_t s);
        case (s)
            DDR_HOLD:             return 3'b100;
            WAIT_CALIB, SYS_HOLD: return 3'b110;
            RUN:                  return 3'b111;
            default:              return 3'b000;
        endcase
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level into core_clk.
// Latency: 2 core_clk edges from input change to q.
// Backpressure: none; continuously samples.
module sync_2ff (
    input  logic core_clk,
    input  logic arst_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge core_clk or negedge arst_n) begin
        if (!arst_n) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/reset_sequencer.sv
// Filters PLL lock and releases debug, DDR and system resets in order; serves run-time system resets.
// Latency: resets are registered, decoded from the next state; async inputs add 2 edges of sync delay.
// Backpressure: none; requests outside RUN/SYS_HOLD are dropped, lock loss overrides everything.
module reset_sequencer
    import reset_seq_pkg::*;
#(
    parameter int LOCK_FILTER        = 16,
    parameter int STRETCH            = 32,
    parameter int CALIB_TIMEOUT_LOG2 = 20
) (
    input  logic       i_clk,
    input  logic       i_nrst,
    input  logic       i_pll_lock,
    input  logic       i_ddr_calib_done,
    input  logic       i_dmireset,
    input  logic       i_sw_reset,
    output logic       o_dbg_nrst,
    output logic       o_ddr_nrst,
    output logic       o_sys_nrst,
    output logic [2:0] o_state,
    output logic       o_calib_timeout
);

    localparam int CNT_W  = CALIB_TIMEOUT_LOG2;
    localparam int LCNT_W = $clog2(LOCK_FILTER + 1);

    localparam logic [LCNT_W-1:0] LOCK_LAST    = LCNT_W'(LOCK_FILTER - 1);
    localparam logic [CNT_W-1:0]  STRETCH_LAST = CNT_W'(STRETCH - 1);
    localparam logic [CNT_W-1:0]  CALIB_LAST   = '1;

    logic              lock_s;
    logic              calib_s;
    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic [LCNT_W-1:0] lock_cnt;
    logic [2:0]        rst_q;
    logic              calib_timeout_q;

    sync_2ff u_sync_lock (
        .core_clk (i_clk),
        .arst_n   (i_nrst),
        .d        (i_pll_lock),
        .q        (lock_s)
    );

    sync_2ff u_sync_calib (
        .core_clk (i_clk),
        .arst_n   (i_nrst),
        .d        (i_ddr_calib_done),
        .q        (calib_s)
    );

    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            state           <= WAIT_LOCK;
            cnt             <= '0;
            lock_cnt        <= '0;
            rst_q           <= 3'b000;
            calib_timeout_q <= 1'b0;
        end else if (state != WAIT_LOCK && !lock_s) begin
            // Losing lock anywhere past the filter drops every domain back into reset.
            state    <= WAIT_LOCK;
            rst_q    <= rst_release(WAIT_LOCK);
            cnt      <= '0;
            lock_cnt <= '0;
        end else begin
            case (state)
                WAIT_LOCK: begin
                    if (!lock_s) begin
                        lock_cnt <= '0;
                    end else if (lock_cnt == LOCK_LAST) begin
                        lock_cnt <= '0;
                        cnt      <= '0;
                        state    <= DDR_HOLD;
                        rst_q    <= rst_release(DDR_HOLD);
                    end else begin
                        lock_cnt <= lock_cnt + 1'b1;
                    end
                end
                DDR_HOLD: begin
                    if (cnt == STRETCH_LAST) begin
                        cnt   <= '0;
                        state <= WAIT_CALIB;
                        rst_q <= rst_release(WAIT_CALIB);
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                WAIT_CALIB: begin
                    cnt <= cnt + 1'b1;
                    // Calibration done beats a timeout landing on the same edge.
                    if (calib_s) begin
                        state <= RUN;
                        rst_q <= rst_release(RUN);
                    end else if (cnt == CALIB_LAST) begin
                        state           <= RUN;
                        rst_q           <= rst_release(RUN);
                        calib_timeout_q <= 1'b1;
                    end
                end
                RUN: begin
                    if (i_dmireset || i_sw_reset) begin
                        cnt   <= '0;
                        state <= SYS_HOLD;
                        rst_q <= rst_release(SYS_HOLD);
                    end
                end
                SYS_HOLD: begin
                    if (i_sw_reset) begin
                        cnt <= '0;
                    end else begin
                        if (cnt != STRETCH_LAST) begin
                            cnt <= cnt + 1'b1;
                        end
                        if (cnt == STRETCH_LAST && !i_dmireset) begin
                            state <= RUN;
                            rst_q <= rst_release(RUN);
                        end
                    end
                end
                default: begin
                    state <= WAIT_LOCK;
                    rst_q <= rst_release(WAIT_LOCK);
                    cnt   <= '0;
                end
            endcase
        end
    end

    assign o_dbg_nrst      = rst_q[2];
    assign o_ddr_nrst      = rst_q[1];
    assign o_sys_nrst      = rst_q[0];
    assign o_state         = state;
    assign o_calib_timeout = calib_timeout_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed and randomized checks of reset_sequencer against edge-count expectations.
module tb_reset_sequencer;

    localparam int LF = 4;
    localparam int ST = 8;
    localparam int TL = 6;
    localparam int TO = 1 << TL;

    logic       clk   = 1'b0;
    logic       nrst  = 1'b1;
    logic       lock  = 1'b0;
    logic       calib = 1'b0;
    logic       dmi   = 1'b0;
    logic       sw    = 1'b0;
    logic       o_dbg_nrst, o_ddr_nrst, o_sys_nrst, o_calib_timeout;
    logic [2:0] o_state;

    int cyc      = 0;
    int n_tests  = 0;
    int n_fail   = 0;
    int drop_cnt = 0;
    bit flag_exp = 1'b0;

    reset_sequencer #(
        .LOCK_FILTER        (LF),
        .STRETCH            (ST),
        .CALIB_TIMEOUT_LOG2 (TL)
    ) dut (
        .i_clk            (clk),
        .i_nrst           (nrst),
        .i_pll_lock       (lock),
        .i_ddr_calib_done (calib),
        .i_dmireset       (dmi),
        .i_sw_reset       (sw),
        .o_dbg_nrst       (o_dbg_nrst),
        .o_ddr_nrst       (o_ddr_nrst),
        .o_sys_nrst       (o_sys_nrst),
        .o_state          (o_state),
        .o_calib_timeout  (o_calib_timeout)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge o_dbg_nrst or negedge o_ddr_nrst) if (nrst) drop_cnt <= drop_cnt + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d failed=%0d", n_tests, n_fail);
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input integer obs, input integer want);
        n_tests++;
        assert (obs === want) else begin
            n_fail++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, want);
        end
    endtask

    function automatic int imax(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    function automatic logic sig(input int sel);
        case (sel)
            0:       return o_dbg_nrst;
            1:       return o_ddr_nrst;
            2:       return o_sys_nrst;
            default: return o_calib_timeout;
        endcase
    endfunction

    // Returns the edge number after which the output first shows val, or -1.
    task automatic wait_for(input int sel, input logic val, input int budget, output int at);
        at = -1;
        for (int i = 0; i < budget && at < 0; i++) begin
            @(posedge clk);
            #1;
            if (sig(sel) === val) at = cyc;
        end
    endtask

    // From WAIT_LOCK with lock low: raise lock (optionally after a short glitch),
    // then assert calibration k negedges after DDR is released.
    task automatic sequence_up(input bit glitch, input int k);
        int c, d_edge, b_edge, rise, want;
        @(negedge clk);
        if (glitch) begin
            lock = 1'b1;
            repeat (3) @(negedge clk);
            lock = 1'b0;
            @(negedge clk);
        end
        lock = 1'b1;
        c = cyc;
        wait_for(0, 1'b1, 40, d_edge);
        check("dbg_release_edge", d_edge, c + LF + 2);
        check("state_ddr_hold", o_state, 1);
        // run-time requests here must have no effect
        @(negedge clk);
        sw  = 1'b1;
        dmi = 1'b1;
        @(negedge clk);
        sw  = 1'b0;
        dmi = 1'b0;
        wait_for(1, 1'b1, 40, b_edge);
        check("ddr_release_edge", b_edge, d_edge + ST);
        check("state_wait_calib", o_state, 2);
        check("sys_still_held", o_sys_nrst, 0);
        check("flag_before_run", o_calib_timeout, flag_exp);
        rise = -1;
        for (int i = 0; i < TO + 20 && rise < 0; i++) begin
            @(negedge clk);
            if (i == k) calib = 1'b1;
            @(posedge clk);
            #1;
            if (o_sys_nrst === 1'b1) rise = cyc;
        end
        want = (k + 3 <= TO) ? b_edge + k + 3 : b_edge + TO;
        if (k + 3 > TO) flag_exp = 1'b1;
        check("sys_release_edge", rise, want);
        check("calib_timeout_flag", o_calib_timeout, flag_exp);
        check("state_run", o_state, 3);
    endtask

    task automatic drop_lock();
        int c;
        @(negedge clk);
        lock  = 1'b0;
        calib = 1'b0;
        c = cyc;
        repeat (2) @(posedge clk);
        #1;
        check("lock_loss_not_early", o_dbg_nrst, 1);
        @(posedge clk);
        #1;
        check("lock_loss_edge", cyc, c + 3);
        check("lock_loss_resets", {o_dbg_nrst, o_ddr_nrst, o_sys_nrst}, 0);
        check("lock_loss_state", o_state, 0);
    endtask

    // Issue a run-time request from RUN: optional sw pulse at step 0, dmireset
    // for dmi_n sampling edges, optional extra sw pulse at step sw_p (1..7).
    task automatic req(input bit sw_first, input int dmi_n, input int sw_p);
        int e0, fall, rise, rel, drops, st_fall;
        drops   = drop_cnt;
        fall    = -1;
        rise    = -1;
        st_fall = -1;
        @(negedge clk);
        e0 = cyc + 1;
        for (int i = 0; i < 80 && rise < 0; i++) begin
            if (i > 0) @(negedge clk);
            sw  = (i == 0 && sw_first) || (i == sw_p);
            dmi = (i < dmi_n);
            @(posedge clk);
            #1;
            if (fall < 0 && o_sys_nrst === 1'b0) begin
                fall    = cyc;
                st_fall = o_state;
            end else if (fall >= 0 && o_sys_nrst === 1'b1) begin
                rise = cyc;
            end
        end
        sw  = 1'b0;
        dmi = 1'b0;
        rel = e0 + ST;
        if (sw_p > 0) rel = imax(rel, e0 + sw_p + ST);
        rel = imax(rel, e0 + dmi_n);
        check("req_fall_edge", fall, e0);
        check("req_hold_state", st_fall, 4);
        check("req_low_cycles", rise - fall, rel - e0);
        check("req_dbg_ddr_kept", drop_cnt, drops);
        check("req_back_in_run", o_state, 3);
    endtask

    initial begin
        int c, d_edge, b_edge, kind, n, p;
        #1 nrst = 1'b0;
        #2;
        check("rst_resets", {o_dbg_nrst, o_ddr_nrst, o_sys_nrst}, 0);
        check("rst_state", o_state, 0);
        check("rst_flag", o_calib_timeout, 0);
        @(negedge clk);
        nrst = 1'b1;

        // Power-up with calibration 20 cycles after DDR release.
        sequence_up(1'b0, 20);
        req(1'b1, 0, -1);
        // dmireset asserted at one edge and released 20 cycles later: 21 sampling edges.
        req(1'b0, 21, -1);

        // Lock glitch, then calibration landing exactly on the timeout edge.
        drop_lock();
        sequence_up(1'b1, TO - 3);

        // Calibration never arrives; flag must survive a later dmireset.
        drop_lock();
        sequence_up(1'b0, 1000);
        req(1'b0, 5, -1);
        check("flag_sticky", o_calib_timeout, 1);

        for (int it = 0; it < 4; it++) begin
            drop_lock();
            sequence_up(1'(it & 1), $urandom_range(0, 70));
            for (int j = 0; j < 4; j++) begin
                repeat ($urandom_range(0, 3)) @(negedge clk);
                kind = $urandom_range(0, 3);
                n    = $urandom_range(1, 24);
                p    = $urandom_range(1, 7);
                case (kind)
                    0:       req(1'b1, 0, -1);
                    1:       req(1'b0, n, -1);
                    2:       req(1'b1, 0, p);
                    default: req(1'b0, n, p);
                endcase
            end
        end

        // Asynchronous reset in the middle of WAIT_CALIB.
        drop_lock();
        @(negedge clk);
        lock = 1'b1;
        wait_for(1, 1'b1, 40, b_edge);
        check("async_pre_state", o_state, 2);
        check("async_pre_flag", o_calib_timeout, flag_exp);
        @(posedge clk);
        #3;
        nrst = 1'b0;
        #1;
        flag_exp = 1'b0;
        check("async_resets", {o_dbg_nrst, o_ddr_nrst, o_sys_nrst}, 0);
        check("async_state", o_state, 0);
        check("async_flag", o_calib_timeout, flag_exp);
        #2;
        nrst = 1'b1;
        c = cyc;
        wait_for(0, 1'b1, 40, d_edge);
        check("async_restart_dbg", d_edge, c + LF + 2);
        check("async_restart_ddr_held", o_ddr_nrst, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
